// File: rtl/al_pkg.sv
// Shared constants and types for the auto-load engine: word format, widths,
// default limits and the state encoding.
package al_pkg;

  localparam int unsigned LAST_BIT        = 15;
  localparam int unsigned ADDR_LSB        = 0;
  localparam int unsigned ADDR_W          = 8;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 7;
  localparam int unsigned WAIT_W          = 10;
  localparam int unsigned STATE_W         = 3;
  localparam int unsigned WAIT_TMO_DEF    = 1023;
  localparam int unsigned MAX_ENTRIES_DEF = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WRITE   = 3'd3,
    ST_FINISH  = 3'd4
  } al_state_e;

  // One register-bus write as assembled from an address/data word pair.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

endpackage

// File: rtl/al_load_engine.sv
// Auto-load responder: drains the PROM-fed FWFT FIFO as address/data pairs
// and replays them as front-end configuration register writes.
module al_load_engine
  import al_pkg::*;
#(
  parameter int unsigned WAIT_TMO    = WAIT_TMO_DEF,
  parameter int unsigned MAX_ENTRIES = MAX_ENTRIES_DEF
) (
  input  logic               CLK,
  input  logic               EOS,
  input  logic               AL_START,
  output logic               AL_DONE,
  output logic               AL_ERR,
  input  logic [DATA_W-1:0]  FIFO_DATA,
  input  logic               FIFO_EMPTY,
  output logic               FIFO_RD,
  output logic               REG_WE,
  output logic [ADDR_W-1:0]  REG_ADDR,
  output logic [DATA_W-1:0]  REG_DATA,
  output logic [CNT_W-1:0]   ENTRY_CNT,
  output logic [STATE_W-1:0] AL_STATE
);

  al_state_e         state_q, state_d;
  logic              start_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  reg_wr_t           wr_q, wr_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rd_c;
  logic              start_edge_c;

  // Address-word bits between the address field and LAST carry no meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^FIFO_DATA[LAST_BIT-1:ADDR_LSB+ADDR_W];

  assign start_edge_c = AL_START & ~start_q;

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= AL_START;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    wr_d    = wr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rd_c    = 1'b0;

    // A dropped request wins over every other decision and silences the FIFO.
    if (state_q != ST_IDLE && !AL_START) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge_c) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
            wait_d  = '0;
            state_d = ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (!FIFO_EMPTY) begin
            rd_c        = 1'b1;
            wr_d.addr   = FIFO_DATA[ADDR_LSB +: ADDR_W];
            last_d      = FIFO_DATA[LAST_BIT];
            wait_d      = '0;
            state_d     = ST_RD_DATA;
          end else if (wait_q == WAIT_W'(WAIT_TMO)) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_RD_DATA: begin
          if (!FIFO_EMPTY) begin
            rd_c      = 1'b1;
            wr_d.data = FIFO_DATA;
            wait_d    = '0;
            state_d   = ST_WRITE;
          end else if (wait_q == WAIT_W'(WAIT_TMO)) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_WRITE: begin
          we_d  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_q) begin
            state_d = ST_FINISH;
          end else if (cnt_d == CNT_W'(MAX_ENTRIES)) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
        ST_FINISH: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign FIFO_RD   = rd_c;
  assign AL_DONE   = done_q;
  assign AL_ERR    = err_q;
  assign REG_WE    = we_q;
  assign REG_ADDR  = wr_q.addr;
  assign REG_DATA  = wr_q.data;
  assign ENTRY_CNT = cnt_q;
  assign AL_STATE  = state_q;

endmodule

// File: tb/tb_al_load_engine.sv
// Directed plus randomized bench for al_load_engine with a FWFT FIFO model,
// a write logger and a pair-level reference model of each load.
module tb_al_load_engine;
  import al_pkg::*;

  logic        CLK = 1'b0;
  logic        EOS;
  logic        AL_START;
  logic        AL_DONE;
  logic        AL_ERR;
  logic [15:0] FIFO_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_RD;
  logic        REG_WE;
  logic [7:0]  REG_ADDR;
  logic [15:0] REG_DATA;
  logic [6:0]  ENTRY_CNT;
  logic [2:0]  AL_STATE;

  al_load_engine dut (
    .CLK        (CLK),
    .EOS        (EOS),
    .AL_START   (AL_START),
    .AL_DONE    (AL_DONE),
    .AL_ERR     (AL_ERR),
    .FIFO_DATA  (FIFO_DATA),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RD    (FIFO_RD),
    .REG_WE     (REG_WE),
    .REG_ADDR   (REG_ADDR),
    .REG_DATA   (REG_DATA),
    .ENTRY_CNT  (ENTRY_CNT),
    .AL_STATE   (AL_STATE)
  );

  always #5 CLK = ~CLK;

  // FWFT FIFO model: words are appended by the stimulus, popped on FIFO_RD.
  logic [15:0] mem [0:1023];
  logic [9:0]  wr_ptr = '0;
  logic [9:0]  rd_ptr = '0;
  logic [9:0]  fifo_lvl;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        stall_en = 1'b0;
  logic        bad_pop = 1'b0;

  assign fifo_lvl   = wr_ptr - rd_ptr;
  assign FIFO_EMPTY = (fifo_lvl == 10'd0) || stall;
  assign FIFO_DATA  = mem[rd_ptr];

  // Write log of every REG_WE pulse with the cycle it was seen at.
  logic [7:0]  log_a [0:255];
  logic [15:0] log_d [0:255];
  int          log_c [0:255];
  int          log_n = 0;
  int          cyc = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (FIFO_RD) begin
      if (FIFO_EMPTY) bad_pop <= 1'b1;
      rd_ptr <= rd_ptr + 10'd1;
    end
    if (REG_WE) begin
      log_a[log_n] <= REG_ADDR;
      log_d[log_n] <= REG_DATA;
      log_c[log_n] <= cyc;
      log_n        <= log_n + 1;
    end
  end

  always @(negedge CLK) stall <= stall_en && ($urandom_range(0, 3) == 0);

  int total = 0;
  int bad = 0;

  logic [15:0] load_q [$];
  logic [7:0]  exp_a [0:255];
  logic [15:0] exp_d [0:255];
  int          exp_n;
  int          exp_used;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the word list pair by pair until LAST or the entry limit.
  task automatic model_load();
    exp_n = 0; exp_used = 0; exp_err = 1'b1;
    for (int i = 0; i + 1 < load_q.size(); i += 2) begin
      exp_a[exp_n] = load_q[i][7:0];
      exp_d[exp_n] = load_q[i+1];
      exp_n++;
      exp_used += 2;
      if (load_q[i][15]) begin exp_err = 1'b0; return; end
      if (exp_n == MAX_ENTRIES_DEF) return;
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic push_load();
    foreach (load_q[i]) push_word(load_q[i]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
  endtask

  // Produce a clean start edge; AL_DONE must be low on the first edge after it.
  task automatic start_load(input string tag, output int s);
    AL_START = 1'b0;
    @(negedge CLK);
    AL_START = 1'b1;
    s = cyc;
    @(negedge CLK);
    chk({tag, ".done_low"}, 32'(AL_DONE), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (AL_DONE !== 1'b1 && n < limit) begin @(negedge CLK); n++; end
    chk({tag, ".done"}, 32'(AL_DONE), 32'd1);
  endtask

  task automatic check_load(input string tag, input int base);
    chk({tag, ".nwr"}, 32'(log_n - base), 32'(exp_n));
    for (int i = 0; i < exp_n && i < log_n - base; i++) begin
      chk($sformatf("%s.a%0d", tag, i), 32'(log_a[base+i]), 32'(exp_a[i]));
      chk($sformatf("%s.d%0d", tag, i), 32'(log_d[base+i]), 32'(exp_d[i]));
    end
    chk({tag, ".cnt"}, 32'(ENTRY_CNT), 32'(exp_n));
    chk({tag, ".err"}, 32'(AL_ERR), 32'(exp_err));
    chk({tag, ".left"}, 32'(fifo_lvl), 32'(load_q.size() - exp_used));
  endtask

  initial begin
    int s, base, n, npairs, lastpos;
    logic [9:0] prev;

    EOS = 1'b0;
    AL_START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst.done", 32'(AL_DONE), 32'd0);
    chk("rst.err", 32'(AL_ERR), 32'd0);
    chk("rst.we", 32'(REG_WE), 32'd0);
    chk("rst.addr", 32'(REG_ADDR), 32'd0);
    chk("rst.data", 32'(REG_DATA), 32'd0);
    chk("rst.cnt", 32'(ENTRY_CNT), 32'd0);
    chk("rst.state", 32'(AL_STATE), 32'(ST_IDLE));
    EOS = 1'b1;
    @(negedge CLK);

    // Two preloaded pairs, second carries LAST.
    load_q = '{16'h0012, 16'hABCD, 16'h8034, 16'h1234};
    push_load(); model_load();
    base = log_n;
    start_load("t1", s);
    wait_done("t1", 100);
    check_load("t1", base);
    chk("t1.lat", 32'(log_c[base]), 32'(s + 4));
    chk("t1.thru", 32'(log_c[base+1]), 32'(s + 7));
    repeat (10) @(negedge CLK);
    chk("t1.hold.nwr", 32'(log_n - base), 32'd2);
    chk("t1.hold.done", 32'(AL_DONE), 32'd1);
    chk("t1.hold.state", 32'(AL_STATE), 32'(ST_IDLE));

    // Data word arrives 10 cycles late.
    load_q = '{16'h8012, 16'hABCD};
    model_load();
    push_word(load_q[0]);
    base = log_n;
    prev = rd_ptr;
    start_load("t2", s);
    n = 0;
    while (rd_ptr == prev && n < 20) begin @(negedge CLK); n++; end
    repeat (10) @(negedge CLK);
    push_word(load_q[1]);
    wait_done("t2", 100);
    check_load("t2", base);
    chk("t2.lat", 32'(log_c[base]), 32'(s + 14));

    // Address only, then the FIFO starves: timeout.
    load_q = '{16'h0055};
    push_load();
    base = log_n;
    start_load("t3", s);
    n = 0;
    while (AL_ERR !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    chk("t3.err_at", 32'(cyc), 32'(s + 1026));
    chk("t3.done_pre", 32'(AL_DONE), 32'd0);
    @(negedge CLK);
    chk("t3.done", 32'(AL_DONE), 32'd1);
    chk("t3.nwr", 32'(log_n - base), 32'd0);
    chk("t3.err", 32'(AL_ERR), 32'd1);

    // 65 pairs without LAST: overflow after 64 writes.
    load_q.delete();
    for (int i = 0; i < 65; i++) begin
      load_q.push_back(16'($urandom) & 16'h7FFF);
      load_q.push_back(16'($urandom));
    end
    push_load(); model_load();
    base = log_n;
    start_load("t4", s);
    wait_done("t4", 1000);
    check_load("t4", base);
    do_flush();

    // Abort after the first write of a 3-pair load, then clean restart.
    load_q.delete();
    for (int i = 0; i < 3; i++) begin
      load_q.push_back((16'($urandom) & 16'h7FFF) | ((i == 2) ? 16'h8000 : 16'h0000));
      load_q.push_back(16'($urandom));
    end
    push_load();
    base = log_n;
    start_load("t5", s);
    chk("t5.err_clr", 32'(AL_ERR), 32'd0);
    n = 0;
    while (REG_WE !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    AL_START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t5.state", 32'(AL_STATE), 32'(ST_IDLE));
    chk("t5.done", 32'(AL_DONE), 32'd0);
    chk("t5.nwr", 32'(log_n - base), 32'd1);
    chk("t5.a0", 32'(log_a[base]), 32'(load_q[0][7:0]));
    chk("t5.left", 32'(fifo_lvl), 32'd4);
    chk("t5.cnt", 32'(ENTRY_CNT), 32'd1);
    do_flush();
    load_q.delete();
    for (int i = 0; i < 2; i++) begin
      load_q.push_back((16'($urandom) & 16'h7FFF) | ((i == 1) ? 16'h8000 : 16'h0000));
      load_q.push_back(16'($urandom));
    end
    push_load(); model_load();
    base = log_n;
    start_load("t5r", s);
    chk("t5r.cnt0", 32'(ENTRY_CNT), 32'd0);
    wait_done("t5r", 100);
    check_load("t5r", base);

    // Random loads with FIFO stalls; some end LAST early leaving words behind.
    stall_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      npairs = int'($urandom_range(1, 8));
      lastpos = (r % 2 == 1) ? npairs - 1 : int'($urandom_range(0, 32'(npairs - 1)));
      load_q.delete();
      for (int i = 0; i < npairs; i++) begin
        load_q.push_back((16'($urandom) & 16'h7FFF) | ((i == lastpos) ? 16'h8000 : 16'h0000));
        load_q.push_back(16'($urandom));
      end
      push_load(); model_load();
      base = log_n;
      start_load($sformatf("t6_%0d", r), s);
      wait_done($sformatf("t6_%0d", r), 2000);
      check_load($sformatf("t6_%0d", r), base);
      do_flush();
    end
    stall_en = 1'b0;

    // Asynchronous reset in the middle of a load.
    load_q.delete();
    for (int i = 0; i < 3; i++) begin
      load_q.push_back(16'h0001 + 16'(i));
      load_q.push_back(16'hFFFF);
    end
    push_load();
    start_load("t7", s);
    repeat (4) @(negedge CLK);
    #2 EOS = 1'b0;
    #1;
    chk("t7.state", 32'(AL_STATE), 32'(ST_IDLE));
    chk("t7.we", 32'(REG_WE), 32'd0);
    chk("t7.addr", 32'(REG_ADDR), 32'd0);
    chk("t7.data", 32'(REG_DATA), 32'd0);
    chk("t7.cnt", 32'(ENTRY_CNT), 32'd0);
    chk("t7.rd", 32'(FIFO_RD), 32'd0);
    AL_START = 1'b0;
    @(negedge CLK);
    EOS = 1'b1;
    base = log_n;
    repeat (6) @(negedge CLK);
    chk("t7.idle", 32'(AL_STATE), 32'(ST_IDLE));
    chk("t7.nwr", 32'(log_n - base), 32'd0);
    chk("t7.done", 32'(AL_DONE), 32'd0);
    do_flush();

    chk("pop_while_empty", 32'(bad_pop), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
